bht_pc_sel: RTL and testbench

- Parametrised successor to the FD-stage PC selector, combining PC-source selection with its own branch history table (BHT) of 2-bit saturating counters.
- Optional global-history (gshare) indexing, selected by parameter.
- Sits between IMEM/FD decode and the PC mux. Receives branch resolution from the X-stage branch checker and keeps prediction/misprediction statistics counters.

---
 rtl/bht_pc_sel.sv | 144 ++++++++++++++
 tb/tb_bht_pc_sel.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bht_pc_sel.sv
// ============================================================================
// Module   : bht_pc_sel
// Brief    : FD-stage PC source selector with 2-bit saturating-counter BHT,
//            optional gshare indexing and branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_pc_sel #(
   parameter int         BHT_ENTRIES = 64,
   parameter int         GHIST_BITS  = 0,
   parameter logic [1:0] INIT_STATE  = 2'b01,
   parameter int         IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       fd_inst,
   input  logic [31:0]       fd_pc,
   input  logic              x_valid,
   input  logic [31:0]       x_pc,
   input  logic [IDX_W-1:0]  x_index,
   input  logic              x_taken,
   input  logic              x_predicted,
   output logic [2:0]        pc_sel,
   output logic              predict,
   output logic [IDX_W-1:0]  fd_index,
   output logic              mispredict,
   output logic [31:0]       branch_count,
   output logic [31:0]       mispredict_count
);

   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_branch = 7'b1100011;

   localparam logic [2:0] c_sel_pc4   = 3'd0;
   localparam logic [2:0] c_sel_alu   = 3'd1;
   localparam logic [2:0] c_sel_imm   = 3'd2;
   localparam logic [2:0] c_sel_pcx4  = 3'd3;
   localparam logic [2:0] c_sel_jalr  = 3'd4;

   logic [1:0]       r_bht [BHT_ENTRIES];
   logic [31:0]      r_branch_count;
   logic [31:0]      r_mispredict_count;
   logic [IDX_W-1:0] w_pc_index;
   logic [IDX_W-1:0] w_fd_index;
   logic [1:0]       w_bht_cur;
   logic [1:0]       w_bht_next;
   logic             w_redirect;
   logic             w_fd_msb;
   logic             w_unused_bits;

   assign w_pc_index = fd_pc[IDX_W+1:2];

   generate
      if (GHIST_BITS > 0) begin : g_gshare
         logic [GHIST_BITS-1:0] r_ghist;

         // History only moves on resolution, so it is never speculative.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ghist <= '0;
            end else if (x_valid) begin
               r_ghist <= GHIST_BITS'({r_ghist, x_taken});
            end
         end

         assign w_fd_index = w_pc_index ^ IDX_W'(r_ghist);
      end else begin : g_bimodal
         assign w_fd_index = w_pc_index;
      end
   endgenerate

   assign fd_index = w_fd_index;
   assign w_fd_msb = r_bht[w_fd_index][1];

   assign w_bht_cur  = r_bht[x_index];
   always_comb begin
      w_bht_next = w_bht_cur;
      if (x_taken) begin
         if (w_bht_cur != 2'b11) w_bht_next = w_bht_cur + 2'd1;
      end else begin
         if (w_bht_cur != 2'b00) w_bht_next = w_bht_cur - 2'd1;
      end
   end

   // Read port is combinational on pre-edge state, giving read-old on collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            r_bht[i] <= INIT_STATE;
         end
      end else if (x_valid) begin
         r_bht[x_index] <= w_bht_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else if (x_valid) begin
         r_branch_count <= r_branch_count + 32'd1;
         if (x_taken != x_predicted) begin
            r_mispredict_count <= r_mispredict_count + 32'd1;
         end
      end
   end

   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;

   assign w_redirect = x_valid & (x_taken ^ x_predicted);

   always_comb begin
      pc_sel     = c_sel_pc4;
      predict    = 1'b0;
      mispredict = 1'b0;
      if (!rst_n) begin
         pc_sel = c_sel_pc4;
      end else if (w_redirect) begin
         mispredict = 1'b1;
         pc_sel     = x_taken ? c_sel_alu : c_sel_pcx4;
      end else begin
         case (fd_inst[6:0])
            c_op_jal:    pc_sel = c_sel_imm;
            c_op_jalr:   pc_sel = c_sel_jalr;
            c_op_branch: begin
               if (w_fd_msb) begin
                  pc_sel  = c_sel_imm;
                  predict = 1'b1;
               end
            end
            default:     pc_sel = c_sel_pc4;
         endcase
      end
   end

   // Inputs carried for interface compatibility but not needed by the logic.
   assign w_unused_bits = ^{x_pc, fd_inst[31:7], fd_pc[31:IDX_W+2], fd_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_bht_pc_sel.sv
// Testbench for bht_pc_sel: behavioural model with per-cycle compare plus
// directed literal checks; a second instance exercises gshare indexing.
`default_nettype none

module tb_bht_pc_sel;

   localparam logic [31:0] BR   = 32'h0000_0063;
   localparam logic [31:0] JAL  = 32'h0000_006F;
   localparam logic [31:0] JALR = 32'h0000_0067;
   localparam logic [31:0] ADDI = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fd_inst, fd_pc, x_pc;
   logic        x_valid, x_taken, x_predicted;
   logic [5:0]  x_index;

   logic [2:0]  pc_sel;
   logic        predict, mispredict;
   logic [5:0]  fd_index;
   logic [31:0] branch_count, mispredict_count;

   logic [2:0]  g_pc_sel;
   logic        g_predict, g_mispredict;
   logic [3:0]  g_fd_index;
   logic [31:0] g_branch_count, g_mispredict_count;

   int n_pass = 0;
   int n_total = 0;

   // Model state
   int          m_cnt [64];
   bit [31:0]   m_bc, m_mc;
   bit [3:0]    m_gh;

   always #5 clk = ~clk;

   bht_pc_sel dut (
      .clk(clk), .rst_n(rst_n), .fd_inst(fd_inst), .fd_pc(fd_pc),
      .x_valid(x_valid), .x_pc(x_pc), .x_index(x_index), .x_taken(x_taken),
      .x_predicted(x_predicted), .pc_sel(pc_sel), .predict(predict),
      .fd_index(fd_index), .mispredict(mispredict),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   bht_pc_sel #(.BHT_ENTRIES(16), .GHIST_BITS(4)) gdut (
      .clk(clk), .rst_n(rst_n), .fd_inst(fd_inst), .fd_pc(fd_pc),
      .x_valid(x_valid), .x_pc(x_pc), .x_index(x_index[3:0]), .x_taken(x_taken),
      .x_predicted(x_predicted), .pc_sel(g_pc_sel), .predict(g_predict),
      .fd_index(g_fd_index), .mispredict(g_mispredict),
      .branch_count(g_branch_count), .mispredict_count(g_mispredict_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: saturating counters as plain integers, stats as modulo-2^32 sums.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) m_cnt[i] = 1;
         m_bc = 0;
         m_mc = 0;
         m_gh = 0;
      end else if (x_valid) begin
         if (x_taken) m_cnt[x_index] = (m_cnt[x_index] >= 3) ? 3 : m_cnt[x_index] + 1;
         else         m_cnt[x_index] = (m_cnt[x_index] <= 0) ? 0 : m_cnt[x_index] - 1;
         m_gh = {m_gh[2:0], x_taken};
         m_bc = m_bc + 1;
         if (x_taken != x_predicted) m_mc = m_mc + 1;
      end
   end

   always @(negedge clk) begin
      int idx, gidx, esel, epred, emis;
      idx   = (fd_pc >> 2) % 64;
      gidx  = ((fd_pc >> 2) % 16) ^ int'(m_gh);
      esel  = 0;
      epred = 0;
      emis  = 0;
      if (rst_n && x_valid && (x_taken != x_predicted)) begin
         emis = 1;
         esel = x_taken ? 1 : 3;
      end else if (rst_n) begin
         case (fd_inst[6:0])
            7'h6F: esel = 2;
            7'h67: esel = 4;
            7'h63: if (m_cnt[idx] >= 2) begin esel = 2; epred = 1; end
            default: esel = 0;
         endcase
      end
      chk("pc_sel", pc_sel, esel);
      chk("predict", predict, epred);
      chk("mispredict", mispredict, emis);
      chk("fd_index", fd_index, idx);
      chk("branch_count", branch_count, m_bc);
      chk("mispredict_count", mispredict_count, m_mc);
      chk("g_fd_index", g_fd_index, gidx);
      chk("g_mispredict", g_mispredict, emis);
   end

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic v,
                        input int idx, input logic t, input logic p);
      @(posedge clk);
      #1;
      fd_inst     = inst;
      fd_pc       = pc;
      x_valid     = v;
      x_index     = 6'(idx);
      x_taken     = t;
      x_predicted = p;
      x_pc        = pc + 32'h40;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      fd_inst = BR; fd_pc = 32'h100; x_pc = 0;
      x_valid = 0; x_index = 0; x_taken = 0; x_predicted = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset defaults
      settle();
      chk("rst_pc_sel", pc_sel, 0);
      chk("rst_predict", predict, 0);
      chk("rst_bcount", branch_count, 0);
      chk("rst_mcount", mispredict_count, 0);

      // Training to saturation, then one not-taken step back to weak-taken
      repeat (4) drive(BR, 32'h100, 1, 0, 1, 1);
      drive(BR, 32'h100, 0, 0, 0, 0);
      settle();
      chk("trained_pc_sel", pc_sel, 2);
      chk("trained_predict", predict, 1);
      chk("trained_bcount", branch_count, 4);
      drive(BR, 32'h100, 1, 0, 0, 0);
      drive(BR, 32'h100, 0, 0, 0, 0);
      settle();
      chk("weak_taken_predict", predict, 1);

      // Redirect priority over JAL and over a predicted-taken branch
      drive(JAL, 32'h100, 1, 1, 0, 1);
      settle();
      chk("redir_nt_pc_sel", pc_sel, 3);
      chk("redir_nt_mispredict", mispredict, 1);
      drive(JAL, 32'h100, 0, 0, 0, 0);
      settle();
      chk("redir_mcount", mispredict_count, 1);
      chk("jal_pc_sel", pc_sel, 2);
      drive(BR, 32'h100, 1, 1, 1, 0);
      settle();
      chk("redir_t_pc_sel", pc_sel, 1);
      chk("redir_t_predict", predict, 0);
      drive(JALR, 32'h200, 0, 0, 0, 0);
      settle();
      chk("jalr_pc_sel", pc_sel, 4);
      chk("redir_mcount2", mispredict_count, 2);
      drive(ADDI, 32'h204, 0, 0, 0, 0);

      // Read-old on same-index collision
      drive(BR, 32'h14, 1, 5, 1, 1);
      settle();
      chk("collide_index", fd_index, 5);
      chk("collide_predict_old", predict, 0);
      drive(BR, 32'h14, 0, 0, 0, 0);
      settle();
      chk("collide_predict_new", predict, 1);

      // gshare history T,T,N,T -> 1101
      drive(ADDI, 32'h0, 1, 9, 1, 1);
      drive(ADDI, 32'h0, 1, 9, 1, 1);
      drive(ADDI, 32'h0, 1, 9, 0, 0);
      drive(ADDI, 32'h0, 1, 9, 1, 1);
      drive(BR, 32'h0, 0, 0, 0, 0);
      settle();
      chk("gshare_index", g_fd_index, 4'hD);
      chk("bimodal_index", fd_index, 0);

      // Statistics wrap
      #1;
      force dut.r_branch_count = 32'hFFFF_FFFF;
      m_bc = 32'hFFFF_FFFF;
      #1;
      release dut.r_branch_count;
      drive(BR, 32'h0, 1, 2, 0, 0);
      drive(BR, 32'h0, 0, 0, 0, 0);
      settle();
      chk("wrap_bcount", branch_count, 0);

      // Asynchronous reset in the middle of an update cycle
      drive(BR, 32'h100, 1, 0, 1, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_bcount", branch_count, 0);
      chk("async_mcount", mispredict_count, 0);
      chk("async_pc_sel", pc_sel, 0);
      chk("async_index", fd_index, 0);
      chk("async_g_index", g_fd_index, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      x_valid = 0;
      settle();
      chk("post_rst_predict", predict, 0);
      chk("post_rst_bcount", branch_count, 0);
      drive(BR, 32'h100, 1, 0, 1, 1);
      drive(BR, 32'h100, 0, 0, 0, 0);
      settle();
      chk("resume_bcount", branch_count, 1);
      chk("resume_predict", predict, 1);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
